roi_frame_stats: RTL

Downstream stage of the radar ROI extractor. Consumes the extracted pixel stream framed by `data_start`/`data_end` and reduces each ROI frame to channel, pixel count, sum, max and min. Presents each result on a valid/ready handshake to the host-side result collector.

---
 rtl/roi_frame_stats.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/roi_frame_stats.sv
// -----------------------------------------------------------------------------
// roi_frame_stats
//
// Reduces each ROI frame coming out of the radar ROI extractor to a small
// summary record: channel, pixel count, pixel sum, maximum and minimum pixel.
// A frame is delimited by data_start (first pixel) and data_end (last pixel).
// Both may be high together for a single-pixel frame. The summary is offered
// to the host-side collector on a valid/ready handshake.
//
// While a result is waiting for the collector (HOLD), a new frame cannot be
// accumulated. If one starts anyway, it is dropped (frame_drop). Its remaining
// pixels are then swallowed in SKIP once the pending result has been taken.
// Framing violations pulse frame_err:
//   - an orphan data_end while idle
//   - data_start inside a frame
//   - data_start while skipping
//
// Optional feature (compile-time macro ROI_MINMAX_EN):
//   defined   : max/min tracking is built and reported on result_max/min
//   undefined : no max/min hardware; result_max and result_min read as 0
//
// Parameters
//   PIX_W  pixel width (must match the extractor's pixel_out)
//   CH_W   channel number width
//   CNT_W  pixel counter width
//   SUM_W  sum width, derived as PIX_W+CNT_W (do not override)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   data_start    first pixel of a frame is on pixel_in
//   data_end      last pixel of a frame is on pixel_in
//   pixel_in      pixel data, valid from data_start through data_end
//   channel_num   channel of the frame, sampled with data_start
//   result_valid  result registers hold a completed frame
//   result_ready  collector accepts the result
//   result_ch     channel of the reported frame
//   result_cnt    pixel count, saturating at 2^CNT_W-1
//   result_sum    pixel sum
//   result_max    largest pixel (0 without ROI_MINMAX_EN)
//   result_min    smallest pixel (0 without ROI_MINMAX_EN)
//   result_ovf    frame was longer than 2^CNT_W-1 pixels
//   frame_err     one-cycle pulse after a framing violation
//   frame_drop    one-cycle pulse after a frame was discarded
// -----------------------------------------------------------------------------
module roi_frame_stats #(
  parameter int PIX_W = 8,
  parameter int CH_W  = 4,
  parameter int CNT_W = 16,
  parameter int SUM_W = PIX_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_start,
  input  logic             data_end,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic [CH_W-1:0]  channel_num,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [CH_W-1:0]  result_ch,
  output logic [CNT_W-1:0] result_cnt,
  output logic [SUM_W-1:0] result_sum,
  output logic [PIX_W-1:0] result_max,
  output logic [PIX_W-1:0] result_min,
  output logic             result_ovf,
  output logic             frame_err,
  output logic             frame_drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2,
    SKIP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state;
  logic   skip_flag;
  logic   skip_nxt;
  logic   handshake;
  logic   load_en;
  logic   accum_en;
  logic   cnt_full;

  assign handshake = result_valid && result_ready;
  assign cnt_full  = (result_cnt == CNT_MAX);

  // A frame is (re)loaded from the current pixel when it starts in IDLE. It
  // is also reloaded when a new start arrives mid-frame; the partial frame is
  // thrown away in that case.
  assign load_en  = data_start && ((state == IDLE) || (state == ACCUM));

  // Once the counter has saturated, every accumulator freezes so the
  // reported sum stays consistent with the reported count.
  assign accum_en = (state == ACCUM) && !data_start && !cnt_full;

  // The skip flag remembers that a frame started while a result was still
  // pending. After the handshake, the rest of that frame is swallowed in
  // SKIP. Any data_end outside ACCUM means no frame is in flight any more,
  // so the flag clears. This also covers a dropped frame that both starts
  // and ends inside HOLD.
  always_comb begin
    skip_nxt = skip_flag;
    if ((state == HOLD) && data_start && !data_end) begin
      skip_nxt = 1'b1;
    end
    if ((state != ACCUM) && data_end) begin
      skip_nxt = 1'b0;
    end
  end

  // Frame sequencing FSM. result_valid is a register that mirrors "next
  // state is HOLD". There is therefore no combinational path from
  // result_ready to any output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      skip_flag    <= 1'b0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
      frame_drop   <= 1'b0;
    end else begin
      skip_flag  <= skip_nxt;
      frame_err  <= 1'b0;
      frame_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (data_start) begin
            state        <= data_end ? HOLD : ACCUM;
            result_valid <= data_end;
          end else if (data_end) begin
            frame_err <= 1'b1;
          end
        end
        ACCUM: begin
          // A start here means the previous end was lost. The datapath
          // restarts the frame; only the error is flagged here.
          if (data_start) begin
            frame_err <= 1'b1;
          end
          if (data_end) begin
            state        <= HOLD;
            result_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (data_start) begin
            frame_drop <= 1'b1;
          end
          if (handshake) begin
            state        <= skip_nxt ? SKIP : IDLE;
            result_valid <= 1'b0;
          end
        end
        SKIP: begin
          if (data_start) begin
            frame_err <= 1'b1;
          end
          if (data_end) begin
            state <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

  // Channel, count, sum and overflow accumulators. They double as the
  // result registers. Nothing writes them in HOLD, so the result stays
  // stable until it has been accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_ch  <= '0;
      result_cnt <= '0;
      result_sum <= '0;
      result_ovf <= 1'b0;
    end else if (load_en) begin
      result_ch  <= channel_num;
      result_cnt <= CNT_ONE;
      result_sum <= SUM_W'(pixel_in);
      result_ovf <= 1'b0;
    end else begin
      if (accum_en) begin
        result_cnt <= result_cnt + CNT_ONE;
        result_sum <= result_sum + SUM_W'(pixel_in);
      end
      if ((state == ACCUM) && cnt_full) begin
        result_ovf <= 1'b1;
      end
    end
  end

`ifdef ROI_MINMAX_EN
  // Unsigned running extremes; they load and freeze together with the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_max <= '0;
      result_min <= '0;
    end else if (load_en) begin
      result_max <= pixel_in;
      result_min <= pixel_in;
    end else if (accum_en) begin
      if (pixel_in > result_max) begin
        result_max <= pixel_in;
      end
      if (pixel_in < result_min) begin
        result_min <= pixel_in;
      end
    end
  end
`else
  assign result_max = '0;
  assign result_min = '0;
`endif

`ifndef SYNTHESIS
  // Internal consistency properties of the FSM and the result registers.
  a_valid_is_hold : assert property (@(posedge clk) disable iff (!rst_n)
    result_valid == (state == HOLD));

  a_skip_only_pending : assert property (@(posedge clk) disable iff (!rst_n)
    skip_flag |-> ((state == HOLD) || (state == SKIP)));

  a_skip_state_has_flag : assert property (@(posedge clk) disable iff (!rst_n)
    (state == SKIP) |-> skip_flag);

  a_result_nonempty : assert property (@(posedge clk) disable iff (!rst_n)
    result_valid |-> (result_cnt != '0));

  a_result_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (result_valid && !result_ready) |=>
      (result_valid && $stable(result_cnt) && $stable(result_sum) &&
       $stable(result_ch) && $stable(result_ovf)));
`endif

endmodule
